// File: rtl/pc_control_pkg.sv
// Shared types and constants for the PC control block: FSM encoding, PC reset/increment
// values and the saturating event-counter width.
package pc_control_pkg;

   typedef enum logic [1:0] {StBoot, StRun, StStall} state_e;

   localparam logic [31:0] PC_RESET = 32'h0;
   localparam logic [31:0] PC_INCR  = 32'd4;
   localparam int unsigned CNT_W    = 16;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Saturating increment: sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
   endfunction

endpackage

// File: rtl/pc_control_if.sv
// Pipeline-side bundle of the PC control block: hazard inputs, redirect targets and the
// PC/pipeline-register steering outputs plus event totals.
interface pc_control_if;
   import pc_control_pkg::*;

   logic             ext_hold;
   logic [31:0]      pc;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic             id_branch;
   logic             id_branch_taken;
   logic             id_jump;
   logic [31:0]      id_branch_target;
   logic [31:0]      id_jump_target;
   logic             idex_regwrite;
   logic             idex_memread;
   logic [4:0]       idex_dest;
   logic [4:0]       exmem_dest;
   logic             exmem_memread;

   logic [31:0]      pc_next;
   logic             pc_hold;
   logic             ifid_hold;
   logic             ifid_flush;
   logic             idex_bubble;
   logic [CNT_W-1:0] stall_total;
   logic [CNT_W-1:0] flush_total;

   modport master (
      output ext_hold, pc, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch, id_branch_taken,
             id_jump, id_branch_target, id_jump_target, idex_regwrite, idex_memread,
             idex_dest, exmem_dest, exmem_memread,
      input  pc_next, pc_hold, ifid_hold, ifid_flush, idex_bubble, stall_total, flush_total
   );

   modport slave (
      input  ext_hold, pc, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch, id_branch_taken,
             id_jump, id_branch_target, id_jump_target, idex_regwrite, idex_memread,
             idex_dest, exmem_dest, exmem_memread,
      output pc_next, pc_hold, ifid_hold, ifid_flush, idex_bubble, stall_total, flush_total
   );

endinterface

// File: rtl/pc_hazard_detect.sv
// Combinational stall-length calculator: how many bubbles the instruction in ID needs
// before its operands (or branch compare inputs) are available.
module pc_hazard_detect (
   input  logic       id_uses_rs_i,
   input  logic       id_uses_rt_i,
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_branch_i,
   input  logic       idex_regwrite_i,
   input  logic       idex_memread_i,
   input  logic [4:0] idex_dest_i,
   input  logic       exmem_memread_i,
   input  logic [4:0] exmem_dest_i,
   output logic [1:0] stall_n_o
);

   logic ex_match;
   logic mem_match;

   // Register 0 is hardwired, so a write to it never creates a dependency.
   function automatic logic dep(input logic [4:0] dest, input logic urs, input logic urt,
                                input logic [4:0] rs, input logic [4:0] rt);
      return (dest != 5'd0) && ((urs && (dest == rs)) || (urt && (dest == rt)));
   endfunction

   assign ex_match  = dep(idex_dest_i, id_uses_rs_i, id_uses_rt_i, id_rs_i, id_rt_i);
   assign mem_match = dep(exmem_dest_i, id_uses_rs_i, id_uses_rt_i, id_rs_i, id_rt_i);

   // Branches resolve in ID, so they cannot use the EX-stage forwarding path.
   always_comb begin
      stall_n_o = 2'd0;
      if (id_branch_i && idex_memread_i && ex_match) begin
         stall_n_o = 2'd2;
      end else if (idex_memread_i && ex_match) begin
         stall_n_o = 2'd1;
      end else if (id_branch_i && idex_regwrite_i && ex_match) begin
         stall_n_o = 2'd1;
      end else if (id_branch_i && exmem_memread_i && mem_match) begin
         stall_n_o = 2'd1;
      end
   end

endmodule

// File: rtl/pc_control.sv
// Next-PC selection and pipeline stall/flush steering for a 5-stage MIPS-style core,
// with saturating stall and redirect totals.
module pc_control
   import pc_control_pkg::*;
(
   input  logic         clk_i,
   input  logic         reset_i,
   pc_control_if.slave  bus
);

   localparam logic [1:0] StallLastCnt = 2'd0;

   state_e           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_total_q, flush_total_q;
   logic [1:0]       stall_n;

   logic [31:0] pc_next;
   logic        pc_hold, ifid_hold, ifid_flush, idex_bubble, redirect;

   pc_hazard_detect u_hazard (
      .id_uses_rs_i    (bus.id_uses_rs),
      .id_uses_rt_i    (bus.id_uses_rt),
      .id_rs_i         (bus.id_rs),
      .id_rt_i         (bus.id_rt),
      .id_branch_i     (bus.id_branch),
      .idex_regwrite_i (bus.idex_regwrite),
      .idex_memread_i  (bus.idex_memread),
      .idex_dest_i     (bus.idex_dest),
      .exmem_memread_i (bus.exmem_memread),
      .exmem_dest_i    (bus.exmem_dest),
      .stall_n_o       (stall_n)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_next     = bus.pc;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      redirect    = 1'b0;
      if (bus.ext_hold) begin
         pc_hold   = 1'b1;
         ifid_hold = 1'b1;
      end else begin
         unique case (state_q)
            StBoot: begin
               pc_next    = PC_RESET;
               pc_hold    = 1'b1;
               ifid_flush = 1'b1;
               state_d    = StRun;
            end
            StRun: begin
               if (stall_n != 2'd0) begin
                  pc_hold     = 1'b1;
                  ifid_hold   = 1'b1;
                  idex_bubble = 1'b1;
                  if (stall_n == 2'd2) begin
                     state_d = StStall;
                     cnt_d   = 2'd0;
                  end
               end else if (bus.id_jump) begin
                  pc_next    = bus.id_jump_target;
                  ifid_flush = 1'b1;
                  redirect   = 1'b1;
               end else if (bus.id_branch && bus.id_branch_taken) begin
                  pc_next    = bus.id_branch_target;
                  ifid_flush = 1'b1;
                  redirect   = 1'b1;
               end else begin
                  pc_next = bus.pc + PC_INCR;
               end
            end
            StStall: begin
               pc_hold     = 1'b1;
               ifid_hold   = 1'b1;
               idex_bubble = 1'b1;
               if (cnt_q == StallLastCnt) begin
                  state_d = StRun;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
            default: state_d = StBoot;
         endcase
      end
      // Reset wins over hold and any stall: present BOOT outputs immediately.
      if (reset_i) begin
         pc_next     = PC_RESET;
         pc_hold     = 1'b1;
         ifid_hold   = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b0;
         redirect    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= StBoot;
         cnt_q         <= 2'd0;
         stall_total_q <= '0;
         flush_total_q <= '0;
      end else if (!bus.ext_hold) begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         stall_total_q <= sat_inc(stall_total_q, idex_bubble);
         flush_total_q <= sat_inc(flush_total_q, redirect);
      end
   end

   assign bus.pc_next     = pc_next;
   assign bus.pc_hold     = pc_hold;
   assign bus.ifid_hold   = ifid_hold;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_bubble = idex_bubble;
   assign bus.stall_total = stall_total_q;
   assign bus.flush_total = flush_total_q;

endmodule

// File: tb/tb_pc_control.sv
// Directed self-checking bench for pc_control: vector table for single-cycle behaviour,
// hand sequences for hold/reset interaction and counter saturation.
module tb_pc_control;
   import pc_control_pkg::*;

   // f = {hold, uses_rs, uses_rt, branch, taken, jump, ex_regwrite, ex_memread, mem_memread}
   // e_o = {pc_hold, ifid_hold, ifid_flush, idex_bubble}
   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  ex_dst;
      logic [4:0]  mem_dst;
      logic [8:0]  f;
      logic [31:0] btgt;
      logic [31:0] jtgt;
      logic [31:0] e_next;
      logic [3:0]  e_o;
      logic [15:0] e_st;
      logic [15:0] e_fl;
   } vec_t;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   pc_control_if bus ();

   pc_control dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.pc               = v.pc;
      bus.id_rs            = v.rs;
      bus.id_rt            = v.rt;
      bus.idex_dest        = v.ex_dst;
      bus.exmem_dest       = v.mem_dst;
      bus.ext_hold         = v.f[8];
      bus.id_uses_rs       = v.f[7];
      bus.id_uses_rt       = v.f[6];
      bus.id_branch        = v.f[5];
      bus.id_branch_taken  = v.f[4];
      bus.id_jump          = v.f[3];
      bus.idex_regwrite    = v.f[2];
      bus.idex_memread     = v.f[1];
      bus.exmem_memread    = v.f[0];
      bus.id_branch_target = v.btgt;
      bus.id_jump_target   = v.jtgt;
   endtask

   // Drive after a rising edge, check mid-cycle, then advance past the next rising edge.
   task automatic apply(input string name, input vec_t v);
      logic [3:0] o;
      drive(v);
      @(negedge clk);
      o = {bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble};
      chk({name, ".pc_next"}, bus.pc_next, v.e_next);
      chk({name, ".ctl"}, {28'd0, o}, {28'd0, v.e_o});
      chk({name, ".stall_total"}, {16'd0, bus.stall_total}, {16'd0, v.e_st});
      chk({name, ".flush_total"}, {16'd0, bus.flush_total}, {16'd0, v.e_fl});
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[20];
   vec_t v;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      v       = '0;
      drive(v);

      //         pc            rs     rt     exd    memd   f             btgt      jtgt
      //         e_next        e_o      st       fl
      tbl[0]  = '{32'h0,       5'd0,  5'd0,  5'd0,  5'd0,  9'b000000000, 32'h0,    32'h0,
                  32'h4,       4'b0000, 16'd0, 16'd0};
      tbl[1]  = '{32'h4,       5'd8,  5'd0,  5'd8,  5'd0,  9'b010000110, 32'h0,    32'h0,
                  32'h4,       4'b1101, 16'd0, 16'd0};
      tbl[2]  = '{32'h4,       5'd0,  5'd0,  5'd0,  5'd0,  9'b000000000, 32'h0,    32'h0,
                  32'h8,       4'b0000, 16'd1, 16'd0};
      tbl[3]  = '{32'h8,       5'd8,  5'd0,  5'd8,  5'd0,  9'b010110110, 32'h40,   32'h0,
                  32'h8,       4'b1101, 16'd1, 16'd0};
      tbl[4]  = '{32'h8,       5'd8,  5'd0,  5'd0,  5'd8,  9'b010110001, 32'h40,   32'h0,
                  32'h8,       4'b1101, 16'd2, 16'd0};
      tbl[5]  = '{32'h8,       5'd8,  5'd0,  5'd0,  5'd0,  9'b010110000, 32'h40,   32'h0,
                  32'h40,      4'b0010, 16'd3, 16'd0};
      tbl[6]  = '{32'h40,      5'd0,  5'd0,  5'd0,  5'd0,  9'b000000000, 32'h0,    32'h0,
                  32'h44,      4'b0000, 16'd3, 16'd1};
      tbl[7]  = '{32'h20,      5'd0,  5'd0,  5'd0,  5'd0,  9'b000001000, 32'h0,    32'h100,
                  32'h100,     4'b0010, 16'd3, 16'd1};
      tbl[8]  = '{32'h100,     5'd0,  5'd5,  5'd5,  5'd0,  9'b001110100, 32'h40,   32'h0,
                  32'h100,     4'b1101, 16'd3, 16'd2};
      tbl[9]  = '{32'h100,     5'd9,  5'd0,  5'd0,  5'd9,  9'b010110001, 32'h40,   32'h0,
                  32'h100,     4'b1101, 16'd4, 16'd2};
      tbl[10] = '{32'h200,     5'd0,  5'd0,  5'd0,  5'd0,  9'b010000110, 32'h0,    32'h0,
                  32'h204,     4'b0000, 16'd5, 16'd2};
      tbl[11] = '{32'h200,     5'd8,  5'd0,  5'd8,  5'd0,  9'b000000110, 32'h0,    32'h0,
                  32'h204,     4'b0000, 16'd5, 16'd2};
      tbl[12] = '{32'h200,     5'd8,  5'd0,  5'd8,  5'd0,  9'b010000100, 32'h0,    32'h0,
                  32'h204,     4'b0000, 16'd5, 16'd2};
      tbl[13] = '{32'h10,      5'd0,  5'd0,  5'd0,  5'd0,  9'b000111000, 32'h40,   32'h300,
                  32'h300,     4'b0010, 16'd5, 16'd2};
      tbl[14] = '{32'hFFFFFFFC, 5'd0, 5'd0,  5'd0,  5'd0,  9'b000000000, 32'h0,    32'h0,
                  32'h0,       4'b0000, 16'd5, 16'd3};
      tbl[15] = '{32'h50,      5'd0,  5'd0,  5'd0,  5'd0,  9'b000100000, 32'h40,   32'h0,
                  32'h54,      4'b0000, 16'd5, 16'd3};
      tbl[16] = '{32'h60,      5'd8,  5'd0,  5'd8,  5'd0,  9'b110000110, 32'h0,    32'h0,
                  32'h60,      4'b1100, 16'd5, 16'd3};
      tbl[17] = '{32'h60,      5'd0,  5'd0,  5'd0,  5'd0,  9'b100001000, 32'h0,    32'h100,
                  32'h60,      4'b1100, 16'd5, 16'd3};
      tbl[18] = '{32'h60,      5'd8,  5'd0,  5'd8,  5'd0,  9'b010001110, 32'h0,    32'h100,
                  32'h60,      4'b1101, 16'd5, 16'd3};
      tbl[19] = '{32'h60,      5'd0,  5'd0,  5'd0,  5'd0,  9'b000000000, 32'h0,    32'h0,
                  32'h64,      4'b0000, 16'd6, 16'd3};

      repeat (2) @(posedge clk);
      #1;

      // Reset asserted, then one BOOT cycle after release, then RUN.
      v = '0; v.e_o = 4'b1010;
      apply("reset", v);
      reset = 1'b0;
      apply("boot", v);

      for (int i = 0; i < 20; i++) begin
         apply($sformatf("vec%0d", i), tbl[i]);
      end

      // Load feeding a branch: two stall cycles, hold during STALL, then reset mid-stall.
      v = '{32'h70, 5'd8, 5'd0, 5'd8, 5'd0, 9'b010110110, 32'h40, 32'h0,
            32'h70, 4'b1101, 16'd6, 16'd3};
      apply("ld_br", v);
      v = '{32'h70, 5'd0, 5'd0, 5'd0, 5'd0, 9'b100000000, 32'h0, 32'h0,
            32'h70, 4'b1100, 16'd7, 16'd3};
      for (int i = 0; i < 3; i++) apply($sformatf("hold%0d", i), v);
      reset = 1'b1;
      v = '{32'h70, 5'd0, 5'd0, 5'd0, 5'd0, 9'b100000000, 32'h0, 32'h0,
            32'h0, 4'b1010, 16'd7, 16'd3};
      apply("rst_in_stall", v);
      reset = 1'b0;
      v = '0; v.e_o = 4'b1010;
      apply("boot2", v);
      v = '0; v.e_next = 32'h4;
      apply("run2", v);

      // Saturation: 65534 load-use bubbles reach 16'hFFFE, three more stick at 16'hFFFF.
      v = '{32'h4, 5'd8, 5'd0, 5'd8, 5'd0, 9'b010000110, 32'h0, 32'h0,
            32'h4, 4'b1101, 16'hFFFE, 16'd0};
      drive(v);
      repeat (65534) @(posedge clk);
      #1;
      apply("sat_fffe", v);
      v.e_st = 16'hFFFF;
      apply("sat_ffff_a", v);
      apply("sat_ffff_b", v);
      apply("sat_ffff_c", v);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_control.md
PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-003 SHALL have port: ext_hold  input  1  debug freeze; holds every state element and counter.
REQ-004 SHALL have port: pc  input  32  current PC register value.
REQ-005 SHALL have port: id_rs, id_rt  input  5 each  source registers of instruction in ID.
REQ-006 SHALL have port: id_uses_rs, id_uses_rt  input  1 each  the ID instruction reads that register.
REQ-007 SHALL have port: id_branch, id_branch_taken  input  1 each  ID holds a beq/bne; the ID comparator says taken.
REQ-008 SHALL have port: id_jump  input  1  ID holds j/jal.
REQ-009 SHALL have port: id_branch_target, id_jump_target  input  32 each  redirect addresses.
REQ-010 SHALL have port: idex_regwrite, idex_memread  input  1 each  control bits of the instruction in EX.
REQ-011 SHALL have port: idex_dest, exmem_dest  input  5 each  destination registers in EX and MEM.
REQ-012 SHALL have port: exmem_memread  input  1  the instruction in MEM is a load.
REQ-013 SHALL have port: pc_next  output  32  next-PC value for the PC register.
REQ-014 SHALL have port: pc_hold, ifid_hold  output  1 each  freeze the PC and the IF/ID register.
REQ-015 SHALL have port: ifid_flush, idex_bubble  output  1 each  zero IF/ID; insert a NOP into ID/EX.
REQ-016 SHALL have port: stall_total, flush_total  output  16 each  saturating event counters.

Function
REQ-017 SHALL implement FSM states BOOT, RUN, STALL; state, stall counter (2 bit) and totals are registered; all other outputs are combinational from state and inputs.
REQ-018 In BOOT: pc_next=0, pc_hold=1, ifid_flush=1; the next state is RUN unconditionally.
REQ-019 A match (X) is: dest!=0 and ((id_uses_rs and dest==id_rs) or (id_uses_rt and dest==id_rt)).
REQ-020 In RUN, the required stall length N is:
- 2 if id_branch and idex_memread and X(idex_dest);
- else 1 if idex_memread and X(idex_dest);
- else 1 if id_branch and idex_regwrite and X(idex_dest);
- else 1 if id_branch and exmem_memread and X(exmem_dest);
- else 0.
REQ-021 When N>=1 in RUN: pc_hold=ifid_hold=idex_bubble=1, pc_next=pc, and no redirect occurs. If N=2, the FSM enters STALL with cnt=0; if N=1, it stays in RUN.
REQ-022 In STALL: pc_hold=ifid_hold=idex_bubble=1, pc_next=pc, and hazard detection is suppressed. The FSM returns to RUN after one cycle, giving exactly N total stall cycles.
REQ-023 In RUN with N=0, priority is:
- id_jump: pc_next=id_jump_target, ifid_flush=1;
- else id_branch and id_branch_taken: pc_next=id_branch_target, ifid_flush=1;
- else pc_next=pc+4 (modulo 2^32), with all control outputs 0.
REQ-024 A data stall SHALL take priority over a taken branch in the same cycle; the branch is re-evaluated after the stall.
REQ-025 stall_total SHALL increment once per cycle in which idex_bubble=1 (BOOT excluded), and flush_total once per redirect; both saturate at 16'hFFFF with no wrap.
REQ-026 While ext_hold=1: state, cnt and totals are unchanged; pc_hold=ifid_hold=1; pc_next=pc; idex_bubble=ifid_flush=0.

Reset
REQ-027 reset=1 at a clock edge SHALL force state=BOOT, cnt=0 and totals=0, overriding ext_hold and any stall in progress.
REQ-028 While reset=1, outputs SHALL equal their BOOT values.

Structure
REQ-029 A shared package SHALL hold the state encoding, PC_RESET=32'h0, PC_INCR=4 and counter width 16.
REQ-030 A combinational sub-module pc_hazard_detect SHALL compute N from the REQ-019/REQ-020 inputs; pc_control instantiates it once.

Verification
REQ-031 Release reset -> BOOT for one cycle (pc_next=0, pc_hold=1), then RUN with pc=0 -> pc_next=4.
REQ-032 idex_memread=1, idex_dest=8, id_rs=8, id_uses_rs=1 -> exactly one cycle of pc_hold=idex_bubble=1; stall_total=1.
REQ-033 Same load with id_branch=1 depending on $8 -> two stall cycles (RUN, then STALL), then taken redirect to id_branch_target=0x40 with ifid_flush=1; flush_total=1.
REQ-034 id_jump=1, id_jump_target=0x100, no hazard, pc=0x20 -> pc_next=0x100 and ifid_flush=1 for one cycle.
REQ-035 ext_hold=1 during the first STALL cycle for 3 cycles, then assert reset mid-STALL -> counters frozen while held; reset then gives BOOT with totals=0.
REQ-036 Force stall_total=16'hFFFE and apply 3 load-use stalls -> the counter reads 16'hFFFF and holds.
